// File: rtl/ic_router.sv
// Buffered NMVU x NMVU crossbar between MVU endpoints: each receiver picks one source
// through a first-word-fallthrough FIFO; senders stall until every subscriber has room.
module ic_router #(
    parameter int NMVU  = 8,
    parameter int W     = 64,
    parameter int DEPTH = 4,
    parameter int BMVUA = $clog2(NMVU),
    parameter int BLVL  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic [NMVU-1:0]       send_en,
    input  logic [NMVU*W-1:0]     send_word,
    output logic [NMVU-1:0]       send_rdy,
    input  logic [NMVU*BMVUA-1:0] recv_from,
    input  logic [NMVU-1:0]       recv_cfg_en,
    output logic [NMVU-1:0]       recv_en,
    output logic [NMVU*W-1:0]     recv_word,
    input  logic [NMVU-1:0]       recv_ack,
    output logic [NMVU*BLVL-1:0]  recv_level,
    output logic [NMVU-1:0]       orphan
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [BLVL-1:0] FULL = BLVL'(DEPTH);

    logic [W-1:0]     mem    [NMVU][DEPTH];
    logic [PW-1:0]    wr_ptr [NMVU];
    logic [PW-1:0]    rd_ptr [NMVU];
    logic [BLVL-1:0]  level  [NMVU];
    logic [BMVUA-1:0] src    [NMVU];
    logic [NMVU-1:0]  orphan_q;
    logic [NMVU-1:0]  has_sub;
    logic [NMVU-1:0]  accept;
    logic [NMVU-1:0]  push;
    logic [NMVU-1:0]  pop;

    // Readiness depends only on registered levels and config, so recv_ack never reaches send_rdy.
    always_comb begin
        has_sub  = '0;
        send_rdy = {NMVU{~clr}};
        for (int j = 0; j < NMVU; j++) begin
            src[j] = recv_from[j*BMVUA +: BMVUA];
            if (recv_cfg_en[j]) begin
                has_sub[src[j]] = 1'b1;
                if (level[j] == FULL) begin
                    send_rdy[src[j]] = 1'b0;
                end
            end
        end
        accept = send_en & send_rdy;
        for (int j = 0; j < NMVU; j++) begin
            push[j] = recv_cfg_en[j] & accept[src[j]];
            pop[j]  = recv_ack[j] & (level[j] != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < NMVU; j++) begin
                wr_ptr[j] <= '0;
                rd_ptr[j] <= '0;
                level[j]  <= '0;
            end
            orphan_q <= '0;
        end else if (clr) begin
            for (int j = 0; j < NMVU; j++) begin
                wr_ptr[j] <= '0;
                rd_ptr[j] <= '0;
                level[j]  <= '0;
            end
            orphan_q <= '0;
        end else begin
            for (int j = 0; j < NMVU; j++) begin
                if (push[j]) begin
                    wr_ptr[j] <= wr_ptr[j] + 1'b1;
                end
                if (pop[j]) begin
                    rd_ptr[j] <= rd_ptr[j] + 1'b1;
                end
                case ({push[j], pop[j]})
                    2'b10:   level[j] <= level[j] + 1'b1;
                    2'b01:   level[j] <= level[j] - 1'b1;
                    default: level[j] <= level[j];
                endcase
            end
            orphan_q <= orphan_q | (accept & ~has_sub);
        end
    end

    // Storage carries no reset; stale entries are never visible because the head is masked when empty.
    always_ff @(posedge clk) begin
        for (int j = 0; j < NMVU; j++) begin
            if (push[j]) begin
                mem[j][wr_ptr[j]] <= send_word[int'(src[j])*W +: W];
            end
        end
    end

    always_comb begin
        recv_en    = '0;
        recv_word  = '0;
        recv_level = '0;
        for (int j = 0; j < NMVU; j++) begin
            recv_en[j]                   = (level[j] != '0);
            recv_word[j*W +: W]          = (level[j] != '0) ? mem[j][rd_ptr[j]] : '0;
            recv_level[j*BLVL +: BLVL]   = level[j];
        end
    end

    assign orphan = orphan_q;

endmodule

// File: tb/tb_ic_router.sv
// Self-checking bench for ic_router: per-receiver expected-word queues plus directed
// sequences for backpressure, multicast stall, orphan, clear and asynchronous reset.
module tb_ic_router;
    localparam int N  = 8;
    localparam int W  = 64;
    localparam int D  = 4;
    localparam int BA = 3;
    localparam int BL = 3;

    logic            clk;
    logic            rst;
    logic            clr;
    logic [N-1:0]    send_en;
    logic [N*W-1:0]  send_word;
    logic [N-1:0]    send_rdy;
    logic [N*BA-1:0] recv_from;
    logic [N-1:0]    recv_cfg_en;
    logic [N-1:0]    recv_en;
    logic [N*W-1:0]  recv_word;
    logic [N-1:0]    recv_ack;
    logic [N*BL-1:0] recv_level;
    logic [N-1:0]    orphan;

    ic_router #(.NMVU(N), .W(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .send_en(send_en), .send_word(send_word), .send_rdy(send_rdy),
        .recv_from(recv_from), .recv_cfg_en(recv_cfg_en),
        .recv_en(recv_en), .recv_word(recv_word), .recv_ack(recv_ack),
        .recv_level(recv_level), .orphan(orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mq [N][$];
    logic [N-1:0] morph;
    logic [2:0]   mfrom [N];
    logic [N-1:0] mcfg;
    logic [W-1:0] wds [N];

    typedef struct {
        logic [N-1:0] en;
        logic [W-1:0] word;
        logic [N-1:0] ack;
        logic         exp_rdy;
        int           exp_lvl;
        logic [W-1:0] exp_head;
    } vec_t;
    vec_t bp [10];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void chk_outs();
        for (int j = 0; j < N; j++) begin
            chk($sformatf("recv_en[%0d]", j), 64'(recv_en[j]), 64'(mq[j].size() > 0));
            chk($sformatf("recv_level[%0d]", j), 64'(recv_level[j*BL +: BL]), 64'(mq[j].size()));
            chk($sformatf("recv_word[%0d]", j), recv_word[j*W +: W],
                (mq[j].size() > 0) ? mq[j][0] : 64'd0);
        end
        chk("orphan", 64'(orphan), 64'(morph));
    endfunction

    function automatic void model_clear();
        for (int j = 0; j < N; j++) mq[j].delete();
        morph = '0;
    endfunction

    // One clock: drive at negedge, check send_rdy before the edge, check outputs #1 after it.
    task automatic cyc(input logic [N-1:0] en, input logic [N-1:0] ack, input logic c,
                       output logic [N-1:0] rdy_seen);
        logic [N-1:0] mrdy;
        logic [N-1:0] acc;
        logic         sub;
        @(negedge clk);
        send_en  = en;
        recv_ack = ack;
        clr      = c;
        for (int i = 0; i < N; i++) begin
            send_word[i*W +: W]  = wds[i];
            recv_from[i*BA +: BA] = mfrom[i];
        end
        recv_cfg_en = mcfg;
        #1;
        for (int i = 0; i < N; i++) begin
            mrdy[i] = !c;
            for (int j = 0; j < N; j++)
                if (mcfg[j] && mfrom[j] == 3'(i) && mq[j].size() >= D) mrdy[i] = 1'b0;
        end
        rdy_seen = send_rdy;
        chk("send_rdy", 64'(send_rdy), 64'(mrdy));
        acc = en & mrdy;
        @(posedge clk);
        #1;
        if (c) begin
            model_clear();
        end else begin
            for (int j = 0; j < N; j++)
                if (ack[j] && mq[j].size() > 0) void'(mq[j].pop_front());
            for (int j = 0; j < N; j++)
                if (mcfg[j] && acc[mfrom[j]]) mq[j].push_back(wds[mfrom[j]]);
            for (int i = 0; i < N; i++) begin
                sub = 1'b0;
                for (int j = 0; j < N; j++)
                    if (mcfg[j] && mfrom[j] == 3'(i)) sub = 1'b1;
                if (acc[i] && !sub) morph[i] = 1'b1;
            end
        end
        chk_outs();
    endtask

    logic [N-1:0] rs;

    initial begin
        bp[0] = '{8'h20, 64'd1, 8'h00, 1'b1, 1, 64'd1};
        bp[1] = '{8'h20, 64'd2, 8'h00, 1'b1, 2, 64'd1};
        bp[2] = '{8'h20, 64'd3, 8'h00, 1'b1, 3, 64'd1};
        bp[3] = '{8'h20, 64'd4, 8'h00, 1'b1, 4, 64'd1};
        bp[4] = '{8'h20, 64'd5, 8'h00, 1'b0, 4, 64'd1};
        bp[5] = '{8'h20, 64'd6, 8'h00, 1'b0, 4, 64'd1};
        bp[6] = '{8'h00, 64'd0, 8'h08, 1'b0, 3, 64'd2};
        bp[7] = '{8'h00, 64'd0, 8'h08, 1'b1, 2, 64'd3};
        bp[8] = '{8'h00, 64'd0, 8'h08, 1'b1, 1, 64'd4};
        bp[9] = '{8'h00, 64'd0, 8'h08, 1'b1, 0, 64'd0};

        rst = 1'b1; clr = 1'b0; send_en = '0; send_word = '0; recv_from = '0;
        recv_cfg_en = '0; recv_ack = '0;
        for (int i = 0; i < N; i++) begin
            mfrom[i] = '0;
            wds[i]   = '0;
        end
        mcfg = '0;
        model_clear();

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("reset recv_en", 64'(recv_en), 64'd0);
        chk("reset recv_level", 64'(recv_level), 64'd0);
        chk("reset orphan", 64'(orphan), 64'd0);
        chk("reset recv_word0", recv_word[0 +: W], 64'd0);
        rst = 1'b0;
        #1;
        chk("post-reset send_rdy", 64'(send_rdy), 64'hFF);

        // Unicast 5 -> 3
        mfrom[3] = 3'd5; mcfg = 8'h08; wds[5] = 64'hA5;
        cyc(8'h20, 8'h00, 1'b0, rs);
        chk("uni recv_en3", 64'(recv_en[3]), 64'd1);
        chk("uni word3", recv_word[3*W +: W], 64'hA5);
        chk("uni level3", 64'(recv_level[3*BL +: BL]), 64'd1);
        cyc(8'h00, 8'h08, 1'b0, rs);
        chk("uni pop level3", 64'(recv_level[3*BL +: BL]), 64'd0);
        chk("uni pop word3", recv_word[3*W +: W], 64'd0);

        // Backpressure and in-order drain
        for (int v = 0; v < 10; v++) begin
            wds[5] = bp[v].word;
            cyc(bp[v].en, bp[v].ack, 1'b0, rs);
            chk($sformatf("bp%0d rdy5", v), 64'(rs[5]), 64'(bp[v].exp_rdy));
            chk($sformatf("bp%0d level3", v), 64'(recv_level[3*BL +: BL]), 64'(bp[v].exp_lvl));
            chk($sformatf("bp%0d head3", v), recv_word[3*W +: W], bp[v].exp_head);
        end

        // Multicast stall: fill receiver 2 from sender 4, then point 1, 2, 7 at sender 0
        mfrom[2] = 3'd4; mcfg = 8'h04;
        for (int k = 0; k < 4; k++) begin
            wds[4] = 64'(100 + k);
            cyc(8'h10, 8'h00, 1'b0, rs);
        end
        mfrom[1] = 3'd0; mfrom[2] = 3'd0; mfrom[7] = 3'd0; mcfg = 8'h86;
        wds[0] = 64'h77;
        cyc(8'h01, 8'h00, 1'b0, rs);
        chk("mc stall rdy0", 64'(rs[0]), 64'd0);
        chk("mc stall level1", 64'(recv_level[1*BL +: BL]), 64'd0);
        chk("mc stall level7", 64'(recv_level[7*BL +: BL]), 64'd0);
        chk("mc stall level2", 64'(recv_level[2*BL +: BL]), 64'd4);
        cyc(8'h01, 8'h04, 1'b0, rs);
        chk("mc pop rdy0", 64'(rs[0]), 64'd0);
        chk("mc pop level2", 64'(recv_level[2*BL +: BL]), 64'd3);
        cyc(8'h01, 8'h00, 1'b0, rs);
        chk("mc go rdy0", 64'(rs[0]), 64'd1);
        chk("mc go level1", 64'(recv_level[1*BL +: BL]), 64'd1);
        chk("mc go level2", 64'(recv_level[2*BL +: BL]), 64'd4);
        chk("mc go level7", 64'(recv_level[7*BL +: BL]), 64'd1);
        chk("mc go word1", recv_word[1*W +: W], 64'h77);
        chk("mc go word7", recv_word[7*W +: W], 64'h77);

        // Full with simultaneous pop, then push+pop at level 3
        wds[0] = 64'h78;
        cyc(8'h01, 8'h04, 1'b0, rs);
        chk("fullpop rdy0", 64'(rs[0]), 64'd0);
        chk("fullpop level2", 64'(recv_level[2*BL +: BL]), 64'd3);
        wds[0] = 64'h79;
        cyc(8'h01, 8'h04, 1'b0, rs);
        chk("pushpop rdy0", 64'(rs[0]), 64'd1);
        chk("pushpop level2", 64'(recv_level[2*BL +: BL]), 64'd3);
        chk("pushpop head2", recv_word[2*W +: W], 64'd103);

        // Orphan and clear
        wds[6] = 64'h66;
        cyc(8'h40, 8'h00, 1'b0, rs);
        chk("orphan rdy6", 64'(rs[6]), 64'd1);
        chk("orphan set", 64'(orphan[6]), 64'd1);
        cyc(8'h00, 8'h00, 1'b0, rs);
        chk("orphan sticky", 64'(orphan[6]), 64'd1);
        cyc(8'h40, 8'h00, 1'b1, rs);
        chk("clr rdy", 64'(rs), 64'd0);
        chk("clr orphan", 64'(orphan), 64'd0);
        chk("clr recv_en", 64'(recv_en), 64'd0);

        // Asynchronous reset between edges with FIFOs partly full
        mfrom[3] = 3'd5; mcfg = 8'h8E; wds[5] = 64'h55; wds[0] = 64'h11;
        cyc(8'h21, 8'h00, 1'b0, rs);
        cyc(8'h40, 8'h00, 1'b0, rs);
        #3;
        rst = 1'b1;
        #1;
        chk("async rst recv_en", 64'(recv_en), 64'd0);
        chk("async rst level", 64'(recv_level), 64'd0);
        chk("async rst orphan", 64'(orphan), 64'd0);
        model_clear();
        send_en = '0; recv_ack = '0; clr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("after rst send_rdy", 64'(send_rdy), 64'hFF);

        // Self-loop
        mfrom[4] = 3'd4; mcfg = 8'h10; wds[4] = 64'h44;
        cyc(8'h10, 8'h00, 1'b0, rs);
        chk("selfloop word4", recv_word[4*W +: W], 64'h44);

        // Random traffic with configuration changes
        for (int seg = 0; seg < 6; seg++) begin
            for (int j = 0; j < N; j++) mfrom[j] = 3'($urandom_range(0, 7));
            mcfg = 8'($urandom);
            for (int k = 0; k < 50; k++) begin
                for (int i = 0; i < N; i++) wds[i] = {$urandom, $urandom};
                cyc(8'($urandom), 8'($urandom), ($urandom_range(0, 63) == 0), rs);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ic_router.md
Name: ic_router

Overview:
- Next-generation MVU interconnect: a buffered NMVU x NMVU crossbar that carries W-bit data words from sending MVUs to receiving MVUs.
- Each receiver selects one source. Several receivers may select the same source, which gives multicast.
- Each receiver has a FIFO of depth DEPTH. Senders see valid/ready backpressure.
- Sits between the MVU interconnect read ports (rdi_*) and write ports (wri_*) inside the MVU array top.

Parameters:
- NMVU, 8, number of MVU endpoints (power of 2, >=2)
- W, 64, data word width (equals the data bank word width)
- DEPTH, 4, per-receiver FIFO depth (power of 2, >=2)
- BMVUA, $clog2(NMVU), derived: source-select width
- BLVL, $clog2(DEPTH+1), derived: occupancy width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- clr  in  1  synchronous clear of all FIFOs and flags
- send_en  in  NMVU  sender i offers send_word slice i
- send_word  in  NMVU*W  sender data, slice i = [i*W +: W]
- send_rdy  out  NMVU  sender i word is accepted this cycle if send_en[i]
- recv_from  in  NMVU*BMVUA  receiver j source select, slice [j*BMVUA +: BMVUA]
- recv_cfg_en  in  NMVU  receiver j subscribed (0 = receiver ignores all traffic)
- recv_en  out  NMVU  receiver j FIFO non-empty (head valid)
- recv_word  out  NMVU*W  receiver j FIFO head
- recv_ack  in  NMVU  pop receiver j head; ignored when recv_en[j]=0
- recv_level  out  NMVU*BLVL  receiver j occupancy, 0..DEPTH
- orphan  out  NMVU  sticky: sender i had a word accepted with no subscriber

Behaviour:
- Reset (rst=1, async) and clr=1 (sync) both do the following:
  - all FIFO pointers and counts go to 0; recv_en=0, recv_level=0, orphan=0;
  - recv_word=0; the output is masked to zero whenever the FIFO is empty.
- send_rdy:
  - Computed only from registered state and config, never from recv_ack.
  - Subscribers of sender i: every j with recv_cfg_en[j]=1 and recv_from[j]==i.
  - send_rdy[i] = AND over subscribers j of (level_j < DEPTH).
  - With no subscribers, send_rdy[i]=1.
  - While clr=1, send_rdy is forced to 0.
  - After reset, all send_rdy are 1.
- Accept:
  - Sender i word accepted when send_en[i] & send_rdy[i].
  - On accept, the word is pushed into every subscriber FIFO in the same cycle (atomic multicast). There is never a partial delivery.
  - An accepted word with zero subscribers is discarded and sets orphan[i] on the next edge.
- Latency: a word accepted at edge k appears at the subscriber FIFO head (recv_en=1) after edge k, provided that FIFO was empty.
- FIFO is first-word-fallthrough:
  - recv_word[j] is the head whenever recv_en[j]=1.
  - recv_ack[j] & recv_en[j] pops on the edge.
- Simultaneous push and pop on the same FIFO:
  - level stays unchanged and ordering is preserved.
  - At level==DEPTH, push is impossible because send_rdy=0, even if a pop occurs that cycle. This keeps the ack->rdy path combinationally cut.
- Ordering: per sender-receiver pair, words arrive in send order.
- Self-loop (recv_from[j]==j) is legal.
- Configuration changes:
  - recv_from and recv_cfg_en are sampled combinationally every cycle.
  - A change affects only future accepts. Words already buffered stay and drain normally.
- Pointers wrap modulo DEPTH; level saturates by construction and never exceeds DEPTH.
- clr takes priority over push and pop in the same cycle.
- Accumulated orphan flags persist until clr or rst.

Test Plan:
- Unicast: rst then release, NMVU=8, DEPTH=4, recv_from[3]=5, recv_cfg_en[3]=1.
  - Sender 5 sends 0xA5 at edge k -> recv_en[3]=1 and recv_word[3]=0xA5 after edge k, recv_level[3]=1.
  - recv_ack pulse -> level 0, recv_word[3]=0.
- Backpressure: receiver 3 subscribed to sender 5, no acks; sender 5 holds send_en for 6 cycles with words 1..6.
  - Exactly 4 accepted; send_rdy[5]=0 from the 5th cycle.
  - Acking afterwards yields 1,2,3,4 in order.
- Multicast stall: receivers 1, 2 and 7 select sender 0; receiver 2 full, receivers 1 and 7 empty.
  - send_rdy[0]=0 and no receiver gets the word.
  - After one pop at receiver 2 -> next offered word lands in all three FIFOs on the same edge.
- Orphan: sender 6 sends with no subscribers -> send_rdy[6]=1, word dropped, orphan[6]=1 after the edge.
  - orphan[6] stays 1 until clr, then 0.
- Full with pop: FIFO at level 4 with recv_ack=1 and send_en=1 in the same cycle -> send_rdy=0, level becomes 3.
  - Next cycle push and pop together keep level at 3, data order intact.
- Reset mid-operation: assert rst asynchronously between edges with FIFOs partially full.
  - recv_en, recv_level and orphan go to 0 immediately.
  - send_rdy = all ones after rst deasserts.
